// File: rtl/elevator_motion_ctrl.sv
// Two-car elevator motion controller: per-car request latch, SCAN scheduling,
// one-floor-at-a-time moves and door dwell. Both cars use the same logic.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | stopped, door closed, choosing next move
// MOVE_UP   | travelling up, timer counts cycles of the floor move
// MOVE_DOWN | travelling down, timer counts cycles of the floor move
// DOOR      | stopped with door open, timer counts the dwell
module elevator_motion_ctrl #(
  parameter int unsigned FLOOR_TICKS = 50_000_000,
  parameter int unsigned DOOR_TICKS  = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] elv1_req,
  input  logic [8:0] elv2_req,
  output logic [4:0] elv1_floor,
  output logic [4:0] elv2_floor,
  output logic [1:0] elv1_dir,
  output logic [1:0] elv2_dir,
  output logic       elv1_door,
  output logic       elv2_door,
  output logic [8:0] elv1_pending,
  output logic [8:0] elv2_pending
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam logic [31:0] FLOOR_LAST = 32'(FLOOR_TICKS - 1);
  localparam logic [31:0] DOOR_LAST  = 32'(DOOR_TICKS - 1);
  localparam logic [1:0]  DIR_UP     = 2'b01;
  localparam logic [1:0]  DIR_DOWN   = 2'b10;
  localparam logic [1:0]  DIR_STOP   = 2'b00;

  // idx is the zero-based floor index (floor 1 -> bit 0)
  function automatic logic [8:0] onehot(input logic [3:0] idx);
    logic [8:0] one;
    one = 9'd1;
    return one << idx;
  endfunction

  function automatic logic [8:0] above_mask(input logic [3:0] idx);
    logic [8:0] all_ones;
    all_ones = 9'h1FF;
    return all_ones << (idx + 4'd1);
  endfunction

  function automatic logic [8:0] below_mask(input logic [3:0] idx);
    logic [8:0] all_ones;
    all_ones = 9'h1FF;
    return ~(all_ones << idx);
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_car
    logic [8:0]  req;
    state_t      state;
    logic [4:0]  floor;
    logic [8:0]  pending;
    logic        last_dir;
    logic [31:0] timer;
    logic [1:0]  dir;
    logic        door;

    logic [3:0]  idx;
    logic [3:0]  next_idx;
    logic [8:0]  cur_oh;
    logic [8:0]  next_oh;
    logic [8:0]  clr;
    logic        has_above;
    logic        has_below;
    logic        more_ahead;
    logic        step_done;
    logic        door_done;
    logic        arrive_door;

    assign req = (c == 0) ? elv1_req : elv2_req;
    assign idx = 4'(floor - 5'd1);

    always_comb begin
      next_idx    = (state == MOVE_DOWN) ? idx - 4'd1 : idx + 4'd1;
      cur_oh      = onehot(idx);
      next_oh     = onehot(next_idx);
      has_above   = |(pending & above_mask(idx));
      has_below   = |(pending & below_mask(idx));
      more_ahead  = (state == MOVE_DOWN) ? |(pending & below_mask(next_idx))
                                         : |(pending & above_mask(next_idx));
      step_done   = (timer == FLOOR_LAST);
      door_done   = (timer == DOOR_LAST);
      arrive_door = ((state == MOVE_UP) || (state == MOVE_DOWN)) && step_done
                    && |(pending & next_oh);
      // Clearing wins over a same-cycle request for the served floor
      clr = '0;
      if (state == DOOR)
        clr = cur_oh;
      else if (arrive_door)
        clr = next_oh;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= IDLE;
        floor    <= 5'd1;
        pending  <= '0;
        last_dir <= 1'b1;
        timer    <= '0;
        dir      <= DIR_STOP;
        door     <= 1'b0;
      end else begin
        pending <= (pending | req) & ~clr;
        unique case (state)
          IDLE: begin
            if (|(pending & cur_oh)) begin
              state <= DOOR;
              timer <= '0;
              dir   <= DIR_STOP;
              door  <= 1'b1;
            end else if (has_above && (last_dir || !has_below)) begin
              state    <= MOVE_UP;
              timer    <= '0;
              last_dir <= 1'b1;
              dir      <= DIR_UP;
            end else if (has_below) begin
              state    <= MOVE_DOWN;
              timer    <= '0;
              last_dir <= 1'b0;
              dir      <= DIR_DOWN;
            end
          end
          MOVE_UP, MOVE_DOWN: begin
            if (step_done) begin
              floor <= (state == MOVE_UP) ? floor + 5'd1 : floor - 5'd1;
              timer <= '0;
              if (arrive_door) begin
                state <= DOOR;
                dir   <= DIR_STOP;
                door  <= 1'b1;
              end else if (!more_ahead) begin
                state <= IDLE;
                dir   <= DIR_STOP;
              end
            end else begin
              timer <= timer + 32'd1;
            end
          end
          DOOR: begin
            if (door_done) begin
              state <= IDLE;
              timer <= '0;
              door  <= 1'b0;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign elv1_floor   = g_car[0].floor;
  assign elv2_floor   = g_car[1].floor;
  assign elv1_dir     = g_car[0].dir;
  assign elv2_dir     = g_car[1].dir;
  assign elv1_door    = g_car[0].door;
  assign elv2_door    = g_car[1].door;
  assign elv1_pending = g_car[0].pending;
  assign elv2_pending = g_car[1].pending;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with FLOOR_TICKS=4, DOOR_TICKS=3.
// "cycle k" is the registered state seen just after the k-th edge following stimulus.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] elv1_req = '0;
  logic [8:0] elv2_req = '0;
  logic [4:0] elv1_floor, elv2_floor;
  logic [1:0] elv1_dir, elv2_dir;
  logic       elv1_door, elv2_door;
  logic [8:0] elv1_pending, elv2_pending;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  elevator_motion_ctrl #(
    .FLOOR_TICKS(4),
    .DOOR_TICKS (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .elv1_req    (elv1_req),
    .elv2_req    (elv2_req),
    .elv1_floor  (elv1_floor),
    .elv2_floor  (elv2_floor),
    .elv1_dir    (elv1_dir),
    .elv2_dir    (elv2_dir),
    .elv1_door   (elv1_door),
    .elv2_door   (elv2_door),
    .elv1_pending(elv1_pending),
    .elv2_pending(elv2_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    elv1_req = '0;
    elv2_req = '0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic pulse(input logic [8:0] r1, input logic [8:0] r2);
    elv1_req = r1;
    elv2_req = r2;
    step();
    elv1_req = '0;
    elv2_req = '0;
  endtask

  task automatic chk_car2_home(input string tag);
    chk({tag, "_c2_floor"}, 32'(elv2_floor), 1);
    chk({tag, "_c2_dir"}, 32'(elv2_dir), 0);
    chk({tag, "_c2_pend"}, 32'(elv2_pending), 0);
  endtask

  initial begin
    // Reset
    do_reset();
    chk("rst_f1", 32'(elv1_floor), 1);
    chk("rst_f2", 32'(elv2_floor), 1);
    chk("rst_d1", 32'(elv1_dir), 0);
    chk("rst_d2", 32'(elv2_dir), 0);
    chk("rst_door", 32'({elv1_door, elv2_door}), 0);
    chk("rst_pend", 32'({elv1_pending, elv2_pending}), 0);

    // Single request to floor 3, then absorbed request at the open door
    pulse(9'h004, 9'h000);
    chk("single_pend", 32'(elv1_pending), 4);
    chk("single_dir_c1", 32'(elv1_dir), 0);
    run_to(2);
    chk("single_dir_c2", 32'(elv1_dir), 1);
    run_to(5);
    chk("single_f_c5", 32'(elv1_floor), 1);
    run_to(6);
    chk("single_f_c6", 32'(elv1_floor), 2);
    chk_car2_home("single6");
    run_to(9);
    chk("single_door_c9", 32'(elv1_door), 0);
    run_to(10);
    chk("single_f_c10", 32'(elv1_floor), 3);
    chk("single_door_c10", 32'(elv1_door), 1);
    chk("single_pend_c10", 32'(elv1_pending), 0);
    chk("single_dir_c10", 32'(elv1_dir), 0);
    pulse(9'h004, 9'h000);
    chk("absorb_pend", 32'(elv1_pending), 0);
    chk("absorb_door_c11", 32'(elv1_door), 1);
    run_to(12);
    chk("absorb_door_c12", 32'(elv1_door), 1);
    run_to(13);
    chk("single_door_c13", 32'(elv1_door), 0);
    run_to(15);
    chk("single_idle_dir", 32'(elv1_dir), 0);
    chk("single_idle_f", 32'(elv1_floor), 3);
    chk("single_idle_door", 32'(elv1_door), 0);
    chk_car2_home("single15");

    // Request at the current floor while idle
    do_reset();
    pulse(9'h001, 9'h000);
    chk("here_pend", 32'(elv1_pending), 1);
    chk("here_door_c1", 32'(elv1_door), 0);
    run_to(2);
    chk("here_door_c2", 32'(elv1_door), 1);
    chk("here_floor", 32'(elv1_floor), 1);
    run_to(3);
    chk("here_pend_clr", 32'(elv1_pending), 0);
    run_to(5);
    chk("here_door_c5", 32'(elv1_door), 0);
    chk("here_floor_c5", 32'(elv1_floor), 1);

    // SCAN: heading to 7, floor 2 requested while passing 5
    do_reset();
    pulse(9'h040, 9'h000);
    run_to(18);
    chk("scan_f_c18", 32'(elv1_floor), 5);
    chk("scan_dir_c18", 32'(elv1_dir), 1);
    run_to(20);
    pulse(9'h002, 9'h000);
    chk("scan_pend_c21", 32'(elv1_pending), 'h042);
    run_to(25);
    chk("scan_dir_c25", 32'(elv1_dir), 1);
    run_to(26);
    chk("scan_f_c26", 32'(elv1_floor), 7);
    chk("scan_door_c26", 32'(elv1_door), 1);
    chk("scan_dir_c26", 32'(elv1_dir), 0);
    chk("scan_pend_c26", 32'(elv1_pending), 'h002);
    run_to(29);
    chk("scan_door_c29", 32'(elv1_door), 0);
    chk("scan_dir_c29", 32'(elv1_dir), 0);
    run_to(30);
    chk("scan_dir_c30", 32'(elv1_dir), 2);
    run_to(34);
    chk("scan_f_c34", 32'(elv1_floor), 6);
    run_to(50);
    chk("scan_f_c50", 32'(elv1_floor), 2);
    chk("scan_door_c50", 32'(elv1_door), 1);
    chk("scan_pend_c50", 32'(elv1_pending), 0);

    // Top floor bound
    do_reset();
    pulse(9'h100, 9'h000);
    run_to(33);
    chk("top_f_c33", 32'(elv1_floor), 8);
    chk("top_door_c33", 32'(elv1_door), 0);
    run_to(34);
    chk("top_f_c34", 32'(elv1_floor), 9);
    chk("top_door_c34", 32'(elv1_door), 1);
    for (int t = 35; t <= 40; t++) begin
      run_to(t);
      chk("top_no_up_at9", 32'(elv1_floor == 5'd9 && elv1_dir == 2'b01), 0);
    end

    // Reset mid-move
    do_reset();
    pulse(9'h010, 9'h000);
    run_to(8);
    chk("rmid_f_c8", 32'(elv1_floor), 2);
    chk("rmid_dir_c8", 32'(elv1_dir), 1);
    reset    = 1'b1;
    elv1_req = 9'h100;
    step();
    reset    = 1'b0;
    elv1_req = '0;
    chk("rmid_floor", 32'(elv1_floor), 1);
    chk("rmid_pend", 32'(elv1_pending), 0);
    chk("rmid_dir", 32'(elv1_dir), 0);

    // Independent cars
    do_reset();
    pulse(9'h100, 9'h008);
    chk("ind_pend1", 32'(elv1_pending), 'h100);
    chk("ind_pend2", 32'(elv2_pending), 'h008);
    run_to(2);
    chk("ind_dirs_c2", 32'({elv1_dir, elv2_dir}), 'b0101);
    run_to(13);
    chk("ind_door2_c13", 32'(elv2_door), 0);
    run_to(14);
    chk("ind_f2_c14", 32'(elv2_floor), 4);
    chk("ind_door2_c14", 32'(elv2_door), 1);
    chk("ind_f1_c14", 32'(elv1_floor), 4);
    chk("ind_dir1_c14", 32'(elv1_dir), 1);
    run_to(17);
    chk("ind_door2_c17", 32'(elv2_door), 0);
    run_to(33);
    chk("ind_door1_c33", 32'(elv1_door), 0);
    run_to(34);
    chk("ind_f1_c34", 32'(elv1_floor), 9);
    chk("ind_door1_c34", 32'(elv1_door), 1);
    chk("ind_f2_c34", 32'(elv2_floor), 4);
    chk("ind_dir2_c34", 32'(elv2_dir), 0);
    chk("ind_pend_c34", 32'({elv1_pending, elv2_pending}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
